keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_if.sv | 22 ++
 rtl/keypad_scanner.sv | 220 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Key handoff bundle between keypad_scanner (master) and the safe controller (slave).
// A key transfers on a clock edge where key_valid and key_ready are both high.
interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_scanner.sv
// 3x4 keypad column scanner and debouncer with a valid/ready holding register.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_FRAMES frames.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV      = 16,
    parameter int unsigned DEBOUNCE      = 4,
    parameter int unsigned REPEAT_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_in,
    output logic [2:0]       col_out,
    keypad_scanner_if.master key
);
    localparam int unsigned     DivW    = $clog2(SCAN_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]      DebLast = 4'(DEBOUNCE);

    typedef enum logic [1:0] {StScan, StDeb, StHeld} state_e;

    logic [3:0]      row_meta_q, row_sync_q;
    logic [DivW-1:0] div_q;
    logic [2:0]      col_q;
    logic [1:0]      hits_q, hits_d;
    logic [3:0]      code_q, code_d;
    state_e          state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      rel_q, rel_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            overrun_q, overrun_d;
    logic            slot_end, frame_end, emit, xfer;
    logic [2:0]      smp_cnt, hit_sum;
    logic [1:0]      smp_row, col_idx;
    logic [3:0]      smp_code;
    logic            res_none, res_key;
`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned    RepW    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_FRAMES - 1);
    logic [RepW-1:0] rep_q, rep_d;
`endif

    assign slot_end  = (div_q == DivLast);
    assign frame_end = slot_end && col_q[2];

    // Decode the synchronized rows seen in the current column slot.
    always_comb begin
        smp_cnt = 3'd0;
        smp_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (row_sync_q[i]) begin
                smp_cnt = smp_cnt + 3'd1;
                smp_row = 2'(i);
            end
        end
        col_idx = 2'd0;
        unique case (col_q)
            3'b001:  col_idx = 2'd0;
            3'b010:  col_idx = 2'd1;
            3'b100:  col_idx = 2'd2;
            default: col_idx = 2'd0;
        endcase
        smp_code = 4'h0;
        if (smp_row == 2'd3) begin
            unique case (col_idx)
                2'd0:    smp_code = 4'hA;
                2'd1:    smp_code = 4'h0;
                default: smp_code = 4'hB;
            endcase
        end else begin
            smp_code = {2'b00, smp_row} * 4'd3 + {2'b00, col_idx} + 4'd1;
        end
    end

    // Hit count saturates at 2; anything above one hit is MULTI.
    always_comb begin
        hits_d  = hits_q;
        code_d  = code_q;
        hit_sum = 3'd0;
        if (slot_end) begin
            hit_sum = {1'b0, hits_q} + smp_cnt;
            hits_d  = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
            if (smp_cnt == 3'd1) code_d = smp_code;
        end
    end

    assign res_none = (hits_d == 2'd0);
    assign res_key  = (hits_d == 2'd1);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (frame_end) begin
            unique case (state_q)
                StScan: begin
                    if (res_key) begin
                        cand_d = code_d;
                        cnt_d  = 4'd1;
                        if (DebLast == 4'd1) begin
                            emit    = 1'b1;
                            rel_d   = 4'd0;
                            state_d = StHeld;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            state_d = StDeb;
                        end
                    end
                end
                StDeb: begin
                    if (res_key && code_d == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DebLast) begin
                            emit    = 1'b1;
                            rel_d   = 4'd0;
                            state_d = StHeld;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        state_d = StScan;
                    end
                end
                StHeld: begin
                    if (res_none) begin
                        rel_d = rel_q + 4'd1;
                        if (rel_q + 4'd1 == DebLast) state_d = StScan;
                    end else begin
                        rel_d = 4'd0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (res_key && code_d == cand_q) begin
                        if (rep_q == RepLast) begin
                            emit  = 1'b1;
                            rep_d = '0;
                        end else begin
                            rep_d = rep_q + RepW'(1);
                        end
                    end else begin
                        rep_d = '0;
                    end
`endif
                end
                default: state_d = StScan;
            endcase
        end
    end

    // A full register that is not draining this cycle drops the new key.
    always_comb begin
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overrun_d   = overrun_q;
        xfer        = key_valid_q && key.key_ready;
        if (xfer) key_valid_d = 1'b0;
        if (emit) begin
            if (!key_valid_q || xfer) begin
                key_valid_d = 1'b1;
                key_code_d  = cand_d;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'd0;
            row_sync_q  <= 4'd0;
            div_q       <= '0;
            col_q       <= 3'b001;
            hits_q      <= 2'd0;
            code_q      <= 4'h0;
            state_q     <= StScan;
            cand_q      <= 4'h0;
            cnt_q       <= 4'd0;
            rel_q       <= 4'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            row_meta_q  <= row_in;
            row_sync_q  <= row_meta_q;
            if (slot_end) begin
                div_q <= '0;
                col_q <= {col_q[1:0], col_q[2]};
            end else begin
                div_q <= div_q + DivW'(1);
            end
            hits_q      <= frame_end ? 2'd0 : hits_d;
            code_q      <= code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign col_out       = col_q;
    assign key.key_code  = key_code_q;
    assign key.key_valid = key_valid_q;
    assign key.overrun   = overrun_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model driven from col_out,
// transfers logged by a monitor, immediate assertions at each check point.
module tb_keypad_scanner;
    localparam int Frame = 48;
    localparam int K1 = 0, K2 = 1, K3 = 2, K5 = 4, K6 = 5, K9 = 8, K0 = 10, KHash = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [2:0]  col_out;
    logic [11:0] pressed = '0;
    int          cyc = 0;
    int          press_cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  got_code[$];
    int          got_cyc[$];

    keypad_scanner_if kif ();

    keypad_scanner dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .row_in  (row_in),
        .col_out (col_out),
        .key     (kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pressed key at (row r, col c) shorts column c onto row r.
    always_comb begin
        row_in = 4'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && col_out[c]) row_in[r] = 1'b1;
    end

    // Logs every transfer; sampled mid low-phase so stimulus has settled.
    always @(negedge clk) begin
        #2;
        if (rst_n && kif.key_valid && kif.key_ready) begin
            got_code.push_back(kif.key_code);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * Frame) @(negedge clk);
    endtask

    task automatic clear_log();
        got_code.delete();
        got_cyc.delete();
    endtask

    initial begin
        kif.key_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col_out), 32'h1);
        check("rst_valid", 32'(kif.key_valid), 32'h0);
        check("rst_overrun", 32'(kif.overrun), 32'h0);
        check("rst_code", 32'(kif.key_code), 32'h0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("col_c15", 32'(col_out), 32'h1);
        @(negedge clk);
        check("col_c16", 32'(col_out), 32'h2);
        repeat (16) @(negedge clk);
        check("col_c32", 32'(col_out), 32'h4);
        repeat (16) @(negedge clk);

        // Hold '5' for 400 cycles.
        kif.key_ready = 1'b1;
        clear_log();
        pressed = 12'(1) << K5;
        press_cyc = cyc;
        repeat (400) @(negedge clk);
        pressed = '0;
        repeat (32) @(negedge clk);
        frames(5);
        check("k5_count", 32'(got_code.size()), 32'd1);
        check("k5_code", (got_code.size() > 0) ? 32'(got_code[0]) : 32'hx, 32'h5);
        check("k5_lat_le_242",
              32'((got_cyc.size() > 0) && (got_cyc[0] - press_cyc <= 242)), 32'd1);

        // Bounce on '9'.
        clear_log();
        pressed = 12'(1) << K9;
        frames(2);
        pressed = '0;
        frames(1);
        pressed = 12'(1) << K9;
        frames(3);
        pressed = '0;
        frames(2);
        check("k9_bounce_none", 32'(got_code.size()), 32'd0);
        pressed = 12'(1) << K9;
        frames(4);
        pressed = '0;
        frames(5);
        check("k9_count", 32'(got_code.size()), 32'd1);
        check("k9_code", (got_code.size() > 0) ? 32'(got_code[0]) : 32'hx, 32'h9);

        // '1' and '6' together, then '1' alone.
        clear_log();
        pressed = (12'(1) << K1) | (12'(1) << K6);
        frames(10);
        check("multi_none", 32'(got_code.size()), 32'd0);
        pressed = 12'(1) << K1;
        frames(4);
        pressed = '0;
        frames(5);
        check("k1_count", 32'(got_code.size()), 32'd1);
        check("k1_code", (got_code.size() > 0) ? 32'(got_code[0]) : 32'hx, 32'h1);

        // Backpressure: '3' held in register, '#' dropped.
        clear_log();
        kif.key_ready = 1'b0;
        pressed = 12'(1) << K3;
        frames(4);
        pressed = '0;
        frames(5);
        pressed = 12'(1) << KHash;
        frames(4);
        pressed = '0;
        frames(5);
        check("bp_valid", 32'(kif.key_valid), 32'd1);
        check("bp_code", 32'(kif.key_code), 32'h3);
        check("bp_overrun", 32'(kif.overrun), 32'd1);
        check("bp_no_xfer", 32'(got_code.size()), 32'd0);
        kif.key_ready = 1'b1;
        @(negedge clk);
        kif.key_ready = 1'b0;
        check("bp_valid_after", 32'(kif.key_valid), 32'd0);
        check("bp_xfer_count", 32'(got_code.size()), 32'd1);
        check("bp_xfer_code", (got_code.size() > 0) ? 32'(got_code[0]) : 32'hx, 32'h3);
        check("bp_overrun_sticky", 32'(kif.overrun), 32'd1);
        repeat (Frame - 1) @(negedge clk);

        // Hold '0' for 21 frames.
        clear_log();
        kif.key_ready = 1'b1;
        pressed = 12'(1) << K0;
        press_cyc = cyc;
        frames(21);
        pressed = '0;
        frames(5);
`ifdef KEYPAD_REPEAT_EN
        check("k0_count", 32'(got_code.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("k0_code", (got_code.size() > i) ? 32'(got_code[i]) : 32'hx, 32'h0);
            check("k0_frame", (got_cyc.size() > i) ? 32'(got_cyc[i] - press_cyc) : 32'hx,
                  32'((4 + 8 * i) * Frame));
        end
`else
        check("k0_count", 32'(got_code.size()), 32'd1);
        check("k0_code", (got_code.size() > 0) ? 32'(got_code[0]) : 32'hx, 32'h0);
        check("k0_frame", (got_cyc.size() > 0) ? 32'(got_cyc[0] - press_cyc) : 32'hx,
              32'(4 * Frame));
`endif

        // Asynchronous reset while a key is pending.
        kif.key_ready = 1'b0;
        pressed = 12'(1) << K2;
        frames(4);
        check("k2_pending_valid", 32'(kif.key_valid), 32'd1);
        check("k2_pending_code", 32'(kif.key_code), 32'h2);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(kif.key_valid), 32'd0);
        check("arst_code", 32'(kif.key_code), 32'h0);
        check("arst_overrun", 32'(kif.overrun), 32'd0);
        check("arst_col", 32'(col_out), 32'h1);
        pressed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
